// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Arbitrates instruction-fetch and data requests onto one single-port memory.
// Data has priority, with a bounded starvation limit for fetch and a per-transaction ack timeout.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;
  typedef enum logic {OwnFetch, OwnData} owner_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
  localparam logic [7:0] TmoLast   = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (!if_req) starve_d = '0;
        if (if_req && (!d_req || starve_q == StarveMax)) begin
          owner_d  = OwnFetch;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wmask_d  = '0;
          wdata_d  = '0;
          starve_d = '0;
          tmo_d    = '0;
          state_d  = StMem;
        end else if (d_req) begin
          owner_d = OwnData;
          addr_d  = d_addr;
          we_d    = d_we;
          wmask_d = d_wmask;
          wdata_d = d_wdata;
          tmo_d   = '0;
          state_d = StMem;
          // Fetch would have won at the limit, so this increment never overshoots it.
          if (if_req) starve_d = starve_q + 4'd1;
        end
      end
      StMem: begin
        // Ack takes precedence over a timeout expiring in the same cycle.
        if (mem_ack) begin
          err_d = 1'b0;
          if (owner_q == OwnFetch) if_rdata_d = mem_rdata;
          else                     d_rdata_d  = mem_rdata;
          state_d = StResp;
        end else if (tmo_q == TmoLast) begin
          err_d = 1'b1;
          if (owner_q == OwnFetch) if_rdata_d = '0;
          else                     d_rdata_d  = '0;
          state_d = StResp;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= OwnFetch;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      starve_q   <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q == StMem);
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;
  assign if_ready  = (state_q == StResp) && (owner_q == OwnFetch);
  assign d_ready   = (state_q == StResp) && (owner_q == OwnData);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while fetch waits, range 1..15.
REQ-002 Parameter TIMEOUT, default 255: cycles to wait for mem_ack before abort, range 1..255.
REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port if_req / if_addr, input, 1/32: instruction-fetch request and byte address.
REQ-006 Port if_ready / if_rdata, output, 1/32: fetch completion pulse and read word.
REQ-007 Port d_req / d_addr / d_we / d_wmask / d_wdata, input, 1/32/1/4/32: data request, address, write enable, byte mask, write word.
REQ-008 Port d_ready / d_rdata, output, 1/32: data completion pulse and read word.
REQ-009 Port err, output, 1: valid with if_ready or d_ready; 1 = transaction timed out.
REQ-010 Port mem_req / mem_addr / mem_we / mem_wmask / mem_wdata, output, 1/32/1/4/32: shared single-port memory request.
REQ-011 Port mem_ack / mem_rdata, input, 1/32: memory completion (1-cycle pulse) and read word, valid with mem_ack.

Function
REQ-012 FSM states SHALL be IDLE, MEM, RESP; an owner register SHALL record FETCH or DATA.
REQ-013 IDLE: if any request pending, SHALL select owner, latch owner's address/we/wmask/wdata, go to MEM; else stay.
REQ-014 Selection: data wins over fetch, except fetch wins when starve counter equals STARVE_LIMIT and if_req=1.
REQ-015 Starve counter: +1 on each data grant while if_req=1; cleared on any fetch grant and when if_req=0 in IDLE; saturates at STARVE_LIMIT.
REQ-016 MEM: mem_req=1 and mem_* driven from latched registers only; requester inputs ignored.
REQ-017 MEM with mem_ack=1: SHALL capture mem_rdata, clear err, go to RESP.
REQ-018 MEM timeout counter: cleared on entry, +1 per cycle without mem_ack; at TIMEOUT cycles without ack SHALL drop mem_req, set err=1, rdata=0, go to RESP.
REQ-019 mem_ack in the same cycle the timeout is reached SHALL count as success (ack wins).
REQ-020 RESP: exactly one cycle; owner's ready=1 with captured rdata; other ready=0; then IDLE.
REQ-021 Requests sampled in RESP SHALL be ignored; the requester drops or replaces its request the cycle after ready.
REQ-022 Latency: request seen in IDLE cycle N -> mem_req cycle N+1; mem_ack cycle M -> ready cycle M+1; minimum request-to-ready 3 cycles.
REQ-023 Writes: mem_we=1 and mem_wmask forwarded; rdata returned on write completion SHALL be mem_rdata as captured (don't-care to requester).
REQ-024 Fetch transactions SHALL always drive mem_we=0, mem_wmask=4'b0000, mem_wdata=0.
REQ-025 mem_ack outside MEM SHALL be ignored.
REQ-026 if_rdata/d_rdata SHALL hold last captured value outside RESP; ready/err only meaningful in RESP.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, owner FETCH, counters 0, mem_req=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0, if_ready=0, d_ready=0, err=0, if_rdata=0, d_rdata=0.
REQ-028 Reset during MEM SHALL abort the transaction with no ready pulse; late mem_ack after reset is ignored.

Verification
REQ-029 if_req=1, if_addr=0x100, mem_ack at 2nd MEM cycle, mem_rdata=0x00000013 -> mem_req one cycle after request, if_ready=1 with if_rdata=0x00000013 one cycle after ack, err=0.
REQ-030 if_req and d_req (d_we=1, d_addr=0x2000, d_wmask=0xF, d_wdata=0xDEADBEEF) same cycle -> data granted first with mem_we=1, mem_wdata=0xDEADBEEF; fetch granted next.
REQ-031 Fetch held pending, d_req reissued continuously, STARVE_LIMIT=4 -> 4 data grants, 5th grant to fetch, counter cleared.
REQ-032 Data read, no mem_ack for 255 cycles -> mem_req drops, d_ready=1 with err=1, d_rdata=0; mem_ack on cycle 255 instead -> err=0.
REQ-033 rst asserted mid-MEM -> outputs zero same cycle, no ready pulse; mem_ack next cycle ignored; new if_req after release served normally.
REQ-034 mem_ack pulsed in IDLE with no request -> no state change, no ready.
